// File: rtl/sprite_fetch_arbiter.sv
// sprite_fetch_arbiter: time-shares the sprite ROM between sprite engines, one SPR_W-pixel row burst at a time.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module sprite_fetch_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int SPR_W   = 16,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 24,
   parameter int ROM_LAT = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*ADDR_W-1:0]     row_addr_i,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic [NUM_REQ-1:0]            done_o,
   output logic                          busy_o,
   output logic [ADDR_W-1:0]             rom_addr_o,
   input  logic [DATA_W-1:0]             rom_data_i,
   output logic                          pix_valid_o,
   output logic [DATA_W-1:0]             pix_data_o,
   output logic [$clog2(NUM_REQ)-1:0]    pix_id_o,
   output logic [$clog2(SPR_W)-1:0]      pix_col_o
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(SPR_W);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t              state_q;
   logic [IDW-1:0]      owner_q;
   logic [IDW-1:0]      win;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W-1:0]   rom_addr_q;
   logic [CW-1:0]       col_q;
   logic [1:0]          lat_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [NUM_REQ-1:0]  done_q;
   logic                busy_q;
   logic                pv_q   [ROM_LAT];
   logic [IDW-1:0]      pid_q  [ROM_LAT];
   logic [CW-1:0]       pcol_q [ROM_LAT];
`ifndef SPRITE_ARB_FIXED_PRIO_EN
   logic [IDW-1:0]      ptr_q;
`endif

   // Pick the next owner; scanning downward lets the nearest candidate overwrite the rest.
   always_comb begin
      win = '0;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req_i[i]) win = IDW'(i);
`else
      for (int i = NUM_REQ; i >= 1; i--)
         if (req_i[(int'(ptr_q) + i) % NUM_REQ]) win = IDW'((int'(ptr_q) + i) % NUM_REQ);
`endif
   end

   // Burst FSM: grant and first address in one edge, SPR_W issues, then wait out the ROM latency.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         base_q     <= '0;
         rom_addr_q <= '0;
         col_q      <= '0;
         lat_q      <= '0;
         grant_q    <= '0;
         done_q     <= '0;
         busy_q     <= 1'b0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
         ptr_q      <= IDW'(NUM_REQ - 1);
`endif
      end else begin
         done_q <= '0;
         case (state_q)
            IDLE: if (|req_i) begin
               base_q     <= row_addr_i[win*ADDR_W +: ADDR_W];
               rom_addr_q <= row_addr_i[win*ADDR_W +: ADDR_W];
               owner_q    <= win;
               grant_q    <= NUM_REQ'(1) << win;
               col_q      <= '0;
               busy_q     <= 1'b1;
               state_q    <= ISSUE;
            end
            ISSUE: if (col_q == CW'(SPR_W - 1)) begin
               state_q <= DRAIN;
               lat_q   <= '0;
               if (ROM_LAT == 1) done_q <= grant_q;
            end else begin
               col_q      <= col_q + 1'b1;
               rom_addr_q <= base_q + ADDR_W'(col_q + 1'b1);
            end
            DRAIN: if (lat_q == 2'(ROM_LAT - 1)) begin
               state_q <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
               ptr_q   <= owner_q;
`endif
            end else begin
               lat_q <= lat_q + 1'b1;
               if (lat_q == 2'(ROM_LAT - 2)) done_q <= grant_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Return pipe: tags each issued address so it lines up with its ROM word.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < ROM_LAT; k++) begin
            pv_q[k]   <= 1'b0;
            pid_q[k]  <= '0;
            pcol_q[k] <= '0;
         end
      end else begin
         pv_q[0]   <= (state_q == ISSUE);
         pid_q[0]  <= owner_q;
         pcol_q[0] <= col_q;
         for (int k = 1; k < ROM_LAT; k++) begin
            pv_q[k]   <= pv_q[k-1];
            pid_q[k]  <= pid_q[k-1];
            pcol_q[k] <= pcol_q[k-1];
         end
      end
   end

   assign grant_o     = grant_q;
   assign done_o      = done_q;
   assign busy_o      = busy_q;
   assign rom_addr_o  = rom_addr_q;
   assign pix_valid_o = pv_q[ROM_LAT-1];
   assign pix_id_o    = pid_q[ROM_LAT-1];
   assign pix_col_o   = pcol_q[ROM_LAT-1];
   assign pix_data_o  = rom_data_i;
endmodule
